// File: rtl/peri_pdm_speaker.sv
// peri_pdm_speaker: Wishbone-programmed PDM transmitter.
// The CPU pushes 8-bit unsigned samples into a small FIFO; a first-order
// sigma-delta modulator turns each sample into OversampleRatio PDM bits,
// paced by a divided bit clock that is exported alongside the data.
module peri_pdm_speaker #(
    parameter int unsigned TicksPerHz      = 2,
    parameter int unsigned OversampleRatio = 32,
    parameter int unsigned FifoDepth       = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wb_we_i,
    input  logic       wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       pdm_clk_o,
    output logic       pdm_dat_o,
    output logic       irq_o
);

    localparam int unsigned DivW = $clog2(TicksPerHz + 2);
    localparam int unsigned CntW = $clog2(OversampleRatio);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [DivW-1:0] DivReload = DivW'(TicksPerHz);
    localparam logic [LvlW-1:0] LvlFull   = LvlW'(FifoDepth);

    // Control and flags
    logic            enable;
    logic            underrun;
    logic            overflow;

    // Bit clock divider
    logic [DivW-1:0] div_cnt;
    logic            pdm_clk_q;

    // Modulator state
    logic [7:0]      acc;
    logic [7:0]      cur;
    logic [CntW-1:0] bit_cnt;
    logic            pdm_dat_q;
    logic            irq_q;

    // Sample FIFO
    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [LvlW-1:0] level;

    // Decoded strobes
    logic            wr_en;
    logic            push_req;
    logic            ctrl_wr;
    logic            clr_flags;
    logic            fifo_empty;
    logic            fifo_full;
    logic            bit_strobe;
    logic            sample_due;
    logic            pop;
    logic            push;
    logic            underrun_set;
    logic            overflow_set;
    logic [7:0]      cur_next;
    logic [8:0]      sum;

    assign wr_en      = wb_stb_i & wb_we_i;
    assign push_req   = wr_en & ~wb_adr_i;
    assign ctrl_wr    = wr_en & wb_adr_i;
    assign clr_flags  = ctrl_wr & wb_dat_i[1];

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LvlFull);

    // A bit is produced in the cycle just before pdm_clk falls.
    assign bit_strobe = enable & pdm_clk_q & (div_cnt == '0);
    assign sample_due = bit_strobe & (bit_cnt == '0);
    assign pop        = sample_due & ~fifo_empty;
    assign underrun_set = sample_due & fifo_empty;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push         = push_req & (~fifo_full | pop);
    assign overflow_set = push_req & fifo_full & ~pop;

    // On an empty FIFO the previous sample keeps playing.
    assign cur_next = pop ? mem[rd_ptr] : cur;
    assign sum      = {1'b0, acc} + {1'b0, cur_next};

    assign wb_ack_o  = wb_stb_i;
    assign pdm_clk_o = pdm_clk_q;
    assign pdm_dat_o = pdm_dat_q;
    assign irq_o     = irq_q;

    // Register read mux: STATUS at address 0, CTRL at address 1.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wb_dat_o = 8'h00;
        if (wb_adr_i) begin
            wb_dat_o = {7'b0, enable};
        end else begin
            wb_dat_o = {4'(level), overflow, underrun, fifo_full, fifo_empty};
        end
    end

    // Enable bit and sticky status flags; a flag-set event beats clear-flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            enable   <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= wb_dat_i[0];
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    // Bit clock divider: counts TicksPerHz..0, toggling pdm_clk at each reload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt   <= DivReload;
            pdm_clk_q <= 1'b0;
        end else if (!enable) begin
            div_cnt   <= DivReload;
            pdm_clk_q <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt   <= DivReload;
            pdm_clk_q <= ~pdm_clk_q;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // Sigma-delta modulator: carry out of acc+cur is the PDM bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc       <= 8'h00;
            cur       <= 8'h00;
            bit_cnt   <= '0;
            pdm_dat_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= pop;
            if (!enable) begin
                acc       <= 8'h00;
                bit_cnt   <= '0;
                pdm_dat_q <= 1'b0;
            end else if (bit_strobe) begin
                cur       <= cur_next;
                acc       <= sum[7:0];
                pdm_dat_q <= sum[8];
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i) begin
        // NOTE: sample storage has no reset; the level counter alone says which entries are valid.
        if (push) begin
            mem[wr_ptr] <= wb_dat_i;
        end
    end

endmodule

// File: tb/tb_peri_pdm_speaker.sv
// Directed bench for peri_pdm_speaker at default parameters
// (bit period 6 cycles, 32 bits per sample, 4-entry FIFO).
module tb_peri_pdm_speaker;

    logic       clk_i;
    logic       rst_ni;
    logic       wb_we_i;
    logic       wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_stb_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       pdm_clk_o;
    logic       pdm_dat_o;
    logic       irq_o;

    peri_pdm_speaker dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .pdm_clk_o (pdm_clk_o),
        .pdm_dat_o (pdm_dat_o),
        .irq_o     (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    // Cycle bookkeeping: cyc counts clock edges since the last enable write edge.
    int   cyc;
    int   irq_cnt;
    int   irq_at [4];
    logic clk_hist [512];
    logic dat_hist [512];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (irq_o === 1'b1) begin
            if (irq_cnt < 4) irq_at[irq_cnt] = cyc;
            irq_cnt++;
        end
        if (cyc >= 0 && cyc < 512) begin
            clk_hist[cyc] = pdm_clk_o;
            dat_hist[cyc] = pdm_dat_o;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wb_write(input logic adr, input logic [7:0] data);
        wb_adr_i = adr;
        wb_dat_i = data;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic wb_read(input logic adr, output logic [7:0] data);
        wb_adr_i = adr;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        #1;
        data = wb_dat_o;
        wb_stb_i = 1'b0;
        #0;
    endtask

    // Enable the modulator and restart the cycle/irq bookkeeping at the write edge.
    task automatic start_run();
        wb_write(1'b1, 8'h01);
        cyc     = 0;
        irq_cnt = 0;
    endtask

    // Gather PDM bits first..first+n-1 (bit k is registered at edge 6+6k).
    function automatic logic [31:0] bits_from(input int first);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 32; k++) v[k] = dat_hist[6 + 6 * (first + k)];
        return v;
    endfunction

    function automatic int popcount32(input logic [31:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 32; k++) n += int'(v[k]);
        return n;
    endfunction

    logic [7:0]  rd;
    logic [11:0] clk_vec;
    logic [31:0] bits;
    int          seen;

    initial begin
        rst_ni   = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 1'b0;
        wb_dat_i = 8'h00;
        wb_stb_i = 1'b0;
        cyc      = -1000;
        irq_cnt  = 0;
        for (int i = 0; i < 4; i++) irq_at[i] = -1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // ---- Reset state ----
        wb_read(1'b0, rd);
        check("reset_status", 32'(rd), 32'h01);
        wb_read(1'b1, rd);
        check("reset_ctrl", 32'(rd), 32'h00);
        check("reset_pdm_clk", 32'(pdm_clk_o), 32'h0);
        check("reset_pdm_dat", 32'(pdm_dat_o), 32'h0);
        check("reset_irq", 32'(irq_o), 32'h0);
        wb_stb_i = 1'b1;
        #1;
        check("ack_follows_stb", 32'(wb_ack_o), 32'h1);
        wb_stb_i = 1'b0;
        ticks(2);

        // ---- Midscale sample 0x80 ----
        wb_write(1'b0, 8'h80);
        wb_read(1'b0, rd);
        check("mid_status_after_push", 32'(rd), 32'h10);
        start_run();
        ticks(192);
        wb_read(1'b0, rd);
        check("mid_status_before_boundary", 32'(rd), 32'h01);
        for (int c = 1; c <= 12; c++) clk_vec[c-1] = clk_hist[c];
        check("divider_waveform", 32'(clk_vec), 32'h71C);
        bits = bits_from(0);
        check("mid_bits", bits, 32'hAAAA_AAAA);
        check("mid_ones", 32'(popcount32(bits)), 32'd16);
        check("mid_first_irq_cycle", 32'(irq_at[0]), 32'd6);
        ticks(6);
        wb_read(1'b0, rd);
        check("mid_underrun_status", 32'(rd), 32'h05);
        ticks(9);
        check("mid_irq_count", 32'(irq_cnt), 32'd1);
        // cycle 207: pdm_clk just rose and bit 33 (a one) is on the line
        check("mid_pre_disable_clk", 32'(pdm_clk_o), 32'h1);
        check("mid_pre_disable_dat", 32'(pdm_dat_o), 32'h1);
        wb_write(1'b1, 8'h00);
        tick();
        check("disable_forces_clk_low", 32'(pdm_clk_o), 32'h0);
        check("disable_forces_dat_low", 32'(pdm_dat_o), 32'h0);
        ticks(10);
        check("disabled_clk_stays_low", 32'(pdm_clk_o), 32'h0);
        wb_read(1'b1, rd);
        check("ctrl_after_disable", 32'(rd), 32'h00);
        wb_write(1'b1, 8'h02);
        wb_read(1'b0, rd);
        check("clear_underrun", 32'(rd), 32'h01);

        // ---- Full-scale then zero ----
        wb_write(1'b0, 8'hFF);
        wb_write(1'b0, 8'h00);
        wb_read(1'b0, rd);
        check("fz_status_after_push", 32'(rd), 32'h20);
        start_run();
        ticks(390);
        bits = bits_from(0);
        check("fs_bits", bits, 32'hFFFF_FFFE);
        check("fs_ones", 32'(popcount32(bits)), 32'd31);
        bits = bits_from(32);
        check("zero_bits", bits, 32'h0000_0000);
        check("fz_irq_count", 32'(irq_cnt), 32'd2);
        check("fz_irq_spacing", 32'(irq_at[1] - irq_at[0]), 32'd192);
        wb_write(1'b1, 8'h02);
        wb_read(1'b0, rd);
        check("fz_clear_disable", 32'(rd), 32'h01);

        // ---- Overflow while disabled ----
        wb_write(1'b0, 8'h11);
        wb_write(1'b0, 8'h22);
        wb_write(1'b0, 8'h33);
        wb_write(1'b0, 8'h44);
        wb_read(1'b0, rd);
        check("full_no_overflow", 32'(rd), 32'h42);
        wb_write(1'b0, 8'h55);
        wb_read(1'b0, rd);
        check("overflow_status", 32'(rd), 32'h4A);
        wb_write(1'b1, 8'h02);
        wb_read(1'b0, rd);
        check("overflow_cleared", 32'(rd), 32'h42);
        wb_read(1'b1, rd);
        check("ctrl_clear_only", 32'(rd), 32'h00);

        // ---- Push into full FIFO on the popping strobe edge ----
        start_run();
        ticks(5);
        wb_write(1'b0, 8'h66);
        check("boundary_irq", 32'(irq_cnt), 32'd1);
        wb_read(1'b0, rd);
        check("boundary_status", 32'(rd), 32'h42);

        // ---- Asynchronous reset mid-sample ----
        ticks(3);
        check("pre_reset_clk_high", 32'(pdm_clk_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_clk", 32'(pdm_clk_o), 32'h0);
        check("async_reset_dat", 32'(pdm_dat_o), 32'h0);
        check("async_reset_irq", 32'(irq_o), 32'h0);
        wb_read(1'b0, rd);
        check("async_reset_status", 32'(rd), 32'h01);
        wb_read(1'b1, rd);
        check("async_reset_ctrl", 32'(rd), 32'h00);
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        cyc     = 0;
        irq_cnt = 0;
        ticks(20);
        seen = 0;
        for (int c = 1; c <= 20; c++) seen += int'(clk_hist[c]) + int'(dat_hist[c]);
        check("post_reset_quiet", 32'(seen), 32'd0);
        check("post_reset_no_irq", 32'(irq_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
